// File: rtl/io_map_pkg.sv
// io_map_pkg: data-memory I/O word map shared by the input mux and the output-port register.
package io_map_pkg;
   localparam logic [5:0] IN0_WORD  = 6'h30;
   localparam logic [5:0] IN1_WORD  = 6'h31;
   localparam logic [5:0] BASE_WORD = 6'h20;
   localparam logic [5:0] STAT_WORD = 6'h28;
   localparam int         VALID_LSB = 0;
   localparam int         OVR_LSB   = 8;
endpackage

// File: rtl/io_output_port.sv
// io_output_port: one output port's data register, unconsumed-data flag and sticky overrun flag.
module io_output_port (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr,
   input  logic        i_ack,
   input  logic        i_ovr_clr,
   input  logic [31:0] i_din,
   output logic [31:0] o_data,
   output logic        o_valid,
   output logic        o_ovr
);
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_ovr;
   logic        w_ack;
   assign w_ack = i_ack & r_valid;
   // an ack in the same cycle as a write consumed the old value, so it is not an overrun
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (i_wr) r_data <= i_din;
         r_valid <= i_wr | (r_valid & ~w_ack);
         r_ovr   <= (i_wr & r_valid & ~w_ack) | (r_ovr & ~i_ovr_clr);
      end
   end
   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_ovr   = r_ovr;
endmodule

// File: rtl/io_output_reg.sv
// io_output_reg: store-addressed output ports with valid/ack handshake, sticky overrun and readback.
module io_output_reg #(
   parameter int         NPORTS    = 3,
   parameter logic [5:0] BASE_WORD = io_map_pkg::BASE_WORD,
   parameter logic [5:0] STAT_WORD = io_map_pkg::STAT_WORD
) (
   input  logic                 io_clk,
   input  logic                 reset,
   input  logic [31:0]          addr,
   input  logic                 io_wen,
   input  logic [31:0]          io_write_data,
   input  logic [NPORTS-1:0]    out_ack,
   output logic [32*NPORTS-1:0] out_port,
   output logic [NPORTS-1:0]    out_valid,
   output logic [31:0]          io_read_data
);
   import io_map_pkg::*;
   logic [5:0]        w_word;
   logic              w_stat_wr;
   logic [NPORTS-1:0] w_ovr;
   logic [31:0]       w_stat;
   logic [31:0]       w_rd;
   logic              w_unused;
   assign w_word    = addr[7:2];
   assign w_stat_wr = io_wen && (w_word == STAT_WORD);
   assign w_unused  = ^{addr[31:8], addr[1:0]};
   for (genvar n = 0; n < NPORTS; n++) begin : g_port
      io_output_port u_port (
         .i_clk    (io_clk),
         .i_rst    (reset),
         .i_wr     (io_wen && (w_word == 6'(BASE_WORD + n))),
         .i_ack    (out_ack[n]),
         .i_ovr_clr(w_stat_wr && io_write_data[OVR_LSB + n]),
         .i_din    (io_write_data),
         .o_data   (out_port[32*n +: 32]),
         .o_valid  (out_valid[n]),
         .o_ovr    (w_ovr[n])
      );
   end
   always_comb begin
      w_stat = '0;
      w_stat[VALID_LSB +: NPORTS] = out_valid;
      w_stat[OVR_LSB +: NPORTS]   = w_ovr;
   end
   always_comb begin
      w_rd = (w_word == STAT_WORD) ? w_stat : 32'h0;
      for (int i = 0; i < NPORTS; i++)
         if (w_word == 6'(BASE_WORD + i)) w_rd = out_port[32*i +: 32];
   end
   assign io_read_data = w_rd;
endmodule

// File: tb/tb_io_output_reg.sv
// tb_io_output_reg: directed stores/acks with a queued scoreboard checked by a negedge monitor.
module tb_io_output_reg;
   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        io_clk = 0;
   logic        reset = 1;
   logic [31:0] addr = 0;
   logic        io_wen = 0;
   logic [31:0] io_write_data = 0;
   logic [2:0]  out_ack = 0;
   logic [95:0] out_port;
   logic [2:0]  out_valid;
   logic [31:0] io_read_data;

   logic        s_wr = 0, s_ack = 0, s_clr = 0;
   logic [31:0] s_dout;
   logic        s_valid, s_ovr;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 io_clk = ~io_clk;

   io_output_reg dut (
      .io_clk       (io_clk),
      .reset        (reset),
      .addr         (addr),
      .io_wen       (io_wen),
      .io_write_data(io_write_data),
      .out_ack      (out_ack),
      .out_port     (out_port),
      .out_valid    (out_valid),
      .io_read_data (io_read_data)
   );

   io_output_port sub (
      .i_clk    (io_clk),
      .i_rst    (reset),
      .i_wr     (s_wr),
      .i_ack    (s_ack),
      .i_ovr_clr(s_clr),
      .i_din    (32'h0),
      .o_data   (s_dout),
      .o_valid  (s_valid),
      .o_ovr    (s_ovr)
   );

   always @(negedge io_clk) begin
      while (q.size() != 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.kind)
            0:       act = out_port[32*e.idx +: 32];
            1:       act = {29'b0, out_valid};
            2:       act = io_read_data;
            default: act = {31'b0, s_ovr};
         endcase
         n_tests++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge io_clk);
      #1;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      io_write_data = d;
      io_wen = 1;
      tick();
      io_wen = 0;
   endtask

   task automatic expect_v(input int kind, input int idx, input logic [31:0] v, input string name);
      exp_t e;
      e.kind = kind;
      e.idx = idx;
      e.exp = v;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] v, input string name);
      addr = a;
      expect_v(2, 0, v, name);
      @(negedge io_clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      reset = 0;
      // reset after some stores clears everything
      sw(32'h80, 32'h11);
      sw(32'h84, 32'h22);
      reset = 1;
      tick();
      tick();
      reset = 0;
      expect_v(0, 0, 32'h0, "rst_port0");
      expect_v(0, 1, 32'h0, "rst_port1");
      expect_v(1, 0, 32'h0, "rst_valid");
      rd(32'hA0, 32'h0, "rst_status");
      // write then ack
      sw(32'h84, 32'hDEADBEEF);
      expect_v(0, 1, 32'hDEADBEEF, "wr_port1");
      expect_v(1, 0, 32'h2, "wr_valid");
      rd(32'h84, 32'hDEADBEEF, "rd_port1");
      out_ack = 3'b010;
      tick();
      out_ack = 0;
      expect_v(1, 0, 32'h0, "ack_valid");
      expect_v(0, 1, 32'hDEADBEEF, "ack_hold_port1");
      // overrun and W1C
      sw(32'h80, 32'h1);
      sw(32'h80, 32'h2);
      expect_v(0, 0, 32'h2, "ovr_port0");
      expect_v(1, 0, 32'h1, "ovr_valid");
      rd(32'hA0, 32'h101, "ovr_status");
      sw(32'hA0, 32'h100);
      rd(32'hA0, 32'h001, "w1c_status");
      // write and ack together on port 2
      sw(32'h88, 32'h33);
      addr = 32'h88;
      io_write_data = 32'h55;
      io_wen = 1;
      out_ack = 3'b100;
      tick();
      io_wen = 0;
      out_ack = 0;
      expect_v(0, 2, 32'h55, "wa_port2");
      expect_v(1, 0, 32'h5, "wa_valid");
      rd(32'hA0, 32'h005, "wa_status");
      // clear then immediate re-overrun
      sw(32'h80, 32'h3);
      rd(32'hA0, 32'h105, "reovr_status");
      sw(32'hA0, 32'h100);
      rd(32'hA0, 32'h005, "clr_status");
      sw(32'h80, 32'h4);
      expect_v(0, 0, 32'h4, "clrset_port0");
      rd(32'hA0, 32'h105, "clrset_status");
      // set and clear on the same edge at port level
      s_wr = 1;
      tick();
      s_clr = 1;
      tick();
      s_wr = 0;
      s_clr = 0;
      expect_v(3, 0, 32'h1, "sub_set_wins");
      s_clr = 1;
      tick();
      s_clr = 0;
      expect_v(3, 0, 32'h0, "sub_clr");
      // decode isolation
      sw(32'h8C, 32'hFFFFFFFF);
      sw(32'hC0, 32'hFFFFFFFF);
      expect_v(0, 0, 32'h4, "iso_port0");
      expect_v(0, 1, 32'hDEADBEEF, "iso_port1");
      expect_v(0, 2, 32'h55, "iso_port2");
      expect_v(1, 0, 32'h5, "iso_valid");
      rd(32'h8C, 32'h0, "rd_unused");
      rd(32'hC0, 32'h0, "rd_input");
      rd(32'hA0, 32'h105, "iso_status");
      // reset beats a simultaneous store
      reset = 1;
      sw(32'h84, 32'h77);
      reset = 0;
      expect_v(0, 1, 32'h0, "rstwr_port1");
      expect_v(1, 0, 32'h0, "rstwr_valid");
      // ack with nothing valid is ignored, so the next store is not an overrun
      out_ack = 3'b010;
      tick();
      out_ack = 0;
      expect_v(1, 0, 32'h0, "idle_ack_valid");
      sw(32'h84, 32'h9);
      rd(32'hA0, 32'h002, "idle_ack_status");
      @(negedge io_clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/io_output_reg.md
Name: io_output_reg

Overview:
CPU-to-peripheral counterpart of the input-port register. It sits on the data-memory I/O region beside the input mux. A store (`sw`) to an output-port address latches the store data into that port's register and raises a per-port valid flag. The peripheral consumes the data with a one-cycle ack, and overwrites of unconsumed data are recorded in sticky overrun bits. Port contents and a status word read back combinationally over io_read_data, so a load (`lw`) completes in the same cycle.

Parameters:
- NPORTS, 3, number of output ports; legal range 1..8.
- BASE_WORD, 6'h20, addr[7:2] of port 0 (byte address 0x80); port n sits at BASE_WORD+n.
- STAT_WORD, 6'h28, addr[7:2] of the status/control word (byte address 0xA0).

Ports:
- io_clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising io_clk.
- addr  in  32  CPU byte address; only addr[7:2] is decoded. I/O-region qualification is done upstream.
- io_wen  in  1  store strobe, already qualified for the I/O region.
- io_write_data  in  32  CPU store data.
- out_ack  in  NPORTS  per-port consume pulse from the peripheral.
- out_port  out  32*NPORTS  port registers; port n occupies bits [32n+31:32n].
- out_valid  out  NPORTS  per-port unconsumed-data flag.
- io_read_data  out  32  combinational readback.

Behaviour:
- Reset (synchronous, active-high): every out_port word = 0, out_valid = 0, overrun = 0. Reset overrides a simultaneous write or ack.
- Port write: io_wen=1 and addr[7:2]==BASE_WORD+n.
  - Next edge: out_port[n] <= io_write_data and out_valid[n] <= 1.
  - Latency is 1 cycle; the data is visible on out_port the cycle after the store.
- Ack: out_ack[n]=1 while out_valid[n]=1 clears out_valid[n] at the next edge.
  - Ack with out_valid[n]=0 is ignored.
  - Ack never alters out_port data; the last value stays held.
- Per-port next state (decided):
  - Write, no ack, valid=0: load data, valid=1.
  - Write, no ack, valid=1: load data, valid stays 1, overrun[n] <= 1 (sticky).
  - Write and ack in the same cycle: load data, valid stays 1, no overrun. The ack consumed the old value.
  - No write, ack: valid <= 0.
  - Neither: hold.
- Status write: io_wen=1 and addr[7:2]==STAT_WORD clears overrun. Bits io_write_data[8+n] are write-1-to-clear for overrun[n]; all other bits are ignored.
  - A status clear and a new overrun on the same port in the same cycle: set wins, so overrun stays 1.
- Store to any other addr[7:2]: no state change.
- Readback (combinational on addr[7:2]):
  - BASE_WORD+n (n<NPORTS): out_port[n].
  - STAT_WORD: {16'b0, overrun padded to 8 bits, out_valid padded to 8 bits}; valid in bits [7:0], overrun in bits [15:8].
  - Anything else: 32'h0.
- Readback reflects state before the current edge; a same-cycle write is not forwarded.
- Out-of-range port words (n >= NPORTS below STAT_WORD) read 0 and ignore writes.

Decomposition:
- Shared package io_map_pkg holds the I/O address map:
  - input words IN0_WORD=6'h30 and IN1_WORD=6'h31;
  - BASE_WORD and STAT_WORD;
  - status field offsets VALID_LSB=0 and OVR_LSB=8.
  - The input mux and this block both import it.
- One sub-module io_output_port holds a single port's data register, valid flag and overrun flag, with inputs wr, ack and ovr_clr. It is instantiated NPORTS times via generate.
- Top level keeps the address decode and the readback mux.

Test Plan:
- Reset: assert reset 2 cycles after random stores -> all out_port=0, out_valid=3'b000, status read = 32'h0.
- Write then ack: sw 32'hDEADBEEF to byte 0x84 -> next cycle out_port1=DEADBEEF, out_valid=3'b010; pulse out_ack[1] -> out_valid=3'b000, out_port1 still DEADBEEF.
- Overrun: sw 1 then 2 to byte 0x80 with no ack -> out_port0=2, out_valid[0]=1, status read = 32'h0000_0101; sw 32'h100 to 0xA0 -> status = 32'h0000_0001.
- Simultaneous write and ack on port 2: valid=1, ack plus sw 32'h55 to 0x88 in the same cycle -> out_port2=55, out_valid[2]=1, overrun[2]=0.
- Clear/set collision: overrun[0]=1, valid[0]=1; status W1C 32'h100 in the cycle of one store to 0x80, then a second store to 0x80 in the next cycle (no ack) -> overrun[0] ends 1; separately, a set and a clear landing on the same edge -> overrun stays 1.
- Decode isolation: sw to 0x8C (unused word) and to 0xC0 (input region) -> no state change; lw at those addresses returns 0 from this block; reset asserted in the same cycle as a store -> the store is discarded.
